// File: rtl/wired_bus_arbiter.sv
// Round-robin owner arbiter for a shared single-driver bus.
// Grants one requester at a time, caps each ownership at MAX_HOLD cycles and
// inserts TA_CYCLES dead cycles after every release so two drivers never overlap.
module wired_bus_arbiter #(
  parameter int unsigned     N         = 4,
  parameter int unsigned     DW        = 8,
  parameter int unsigned     MAX_HOLD  = 4,
  parameter int unsigned     TA_CYCLES = 1,
  parameter logic [DW-1:0]   IDLE_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      wdata,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic [DW-1:0]        bus_data,
  output logic                 bus_valid,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned TW = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TA_LAST   = TW'(TA_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT      = 2'd1,
    S_TURNAROUND = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] ta_q, ta_d;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] cand;
  logic          release_now;

  // Round-robin search: first requester at or after rr_q, wrapping modulo N
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((32'(rr_q) + 32'(i)) % N);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Owner gives up the bus when it drops its request or exhausts its hold budget
  always_comb begin
    release_now = (!req[owner_q]) || (hold_q == HOLD_LAST);
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    ta_d    = ta_q;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          owner_d = sel_idx;
          hold_d  = '0;
        end
      end

      S_GRANT: begin
        if (release_now) begin
          state_d = S_TURNAROUND;
          gnt_d   = '0;
          rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
          ta_d    = '0;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end

      S_TURNAROUND: begin
        if (ta_q == TA_LAST) begin
          state_d = S_IDLE;
        end else begin
          ta_d    = ta_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      ta_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      ta_q    <= ta_d;
    end
  end

  // Bus value: the granted lane, otherwise the idle value (grant is one-hot)
  always_comb begin
    bus_data = IDLE_VAL;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        bus_data = wdata[i*DW +: DW];
      end
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign bus_valid = |gnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
